issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  async active-high reset
- id_is_valid  in  1  decoded instruction present
- id_is_functionalunit  in  2  0 none, 1 X pipe (latency 4), 2 M pipe (latency 2), 3 reserved
- id_is_rs, id_is_rt  in  5 each  source registers
- id_is_readrs, id_is_readrt  in  1 each  source actually read
- id_is_regdest  in  5  destination register
- id_is_writereg  in  1  instruction writes regdest
- wb_is_regdest  in  5  register retired by writeback this cycle
- wb_is_writereg  in  1  writeback retire valid
- is_id_stall  out  1  hold decode this cycle
- is_x_issue  out  1  issue to X pipe this cycle
- is_m_issue  out  1  issue to M pipe this cycle
- is_stallcount  out  16  saturating count of stall cycles

Function
REQ-003 State SHALL be: pending[31:1] scoreboard, wb_busy[3:1] writeback-port claims, 16-bit stall counter; register 0 is never pending.
REQ-004 wb_busy[k] set SHALL mean the single writeback port is claimed k cycles after the current cycle.
REQ-005 A source hazard SHALL exist when (readrs and pending[rs]) or (readrt and pending[rt]), for nonzero rs/rt.
REQ-006 A WAW hazard SHALL exist when writereg and regdest!=0 and pending[regdest].
REQ-007 A structural hazard SHALL exist when functionalunit==2 and wb_busy[2] is set; an X issue never conflicts.
REQ-008 Unit 3 SHALL be treated as unit 0 (no issue, no stall).
REQ-009 go = valid and unit in {1,2} and no hazard; is_x_issue = go and unit==1; is_m_issue = go and unit==2; combinational from registered state.
REQ-010 is_id_stall SHALL equal valid and unit in {1,2} and not go; never asserted when valid=0.
REQ-011 On each edge wb_busy SHALL shift (new[k]=old[k+1], new[3]=0), then X issue sets new[3], M issue sets new[1].
REQ-012 Writeback retire SHALL clear pending[wb_is_regdest] at the edge; issue with writereg sets pending[regdest] at the edge.
REQ-013 Simultaneous retire and set of the same register SHALL leave it set.
REQ-014 Stall counter SHALL increment on each edge where is_id_stall=1 and hold at 16'hFFFF.
REQ-015 At most one instruction SHALL issue per cycle; latency from issue to scoreboard update is one edge.

Reset
REQ-016 While reset is high: pending, wb_busy and stall counter SHALL be zero, asynchronously.
REQ-017 While reset is high: is_x_issue=0, is_m_issue=0, is_id_stall=1 regardless of inputs; is_stallcount=0.
REQ-018 Reset deasserted mid-operation SHALL discard all claims; first post-reset instruction with no hazards issues in that cycle.

Configuration
REQ-019 Macro ISSUE_WB_BYPASS_EN SHALL control same-cycle retire bypass.
REQ-020 With ISSUE_WB_BYPASS_EN defined: a source or destination whose pending bit is being cleared by the current writeback SHALL be treated as not pending for REQ-005/006.
REQ-021 Without it: hazard checks use registered pending only; the instruction issues one cycle after retire.

Verification
REQ-022 After reset, X issue rd=5, next cycle valid rs=5 X -> stall until wb_is_regdest=5 retire; issue on cycle after retire (same cycle if ISSUE_WB_BYPASS_EN).
REQ-023 X issue at cycle N, M issue attempted at N+2 with no data hazard -> is_id_stall=1 at N+2, M issues at N+3.
REQ-024 Retire rd=7 and new issue writing rd=7 in same cycle -> pending[7]=1 after edge; next reader of r7 stalls.
REQ-025 Reader of r0 with writereg rd=0 issued earlier -> no stall; pending never set for r0.
REQ-026 Hold stall 70000 cycles -> is_stallcount saturates at 16'hFFFF; assert reset mid-stall -> count 0, stall=1, issues 0 during reset.

Source files
------------

// File: rtl/issue_scheduler.sv
// issue_scheduler: scoreboard issue control for the X (latency 4) and M (latency 2) pipes sharing one writeback port.
// Optional macro ISSUE_WB_BYPASS_EN: a register retiring this cycle is treated as not pending in the hazard checks.
module issue_scheduler (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_is_valid,
   input  logic [1:0]  id_is_functionalunit,
   input  logic [4:0]  id_is_rs,
   input  logic [4:0]  id_is_rt,
   input  logic        id_is_readrs,
   input  logic        id_is_readrt,
   input  logic [4:0]  id_is_regdest,
   input  logic        id_is_writereg,
   input  logic [4:0]  wb_is_regdest,
   input  logic        wb_is_writereg,
   output logic        is_id_stall,
   output logic        is_x_issue,
   output logic        is_m_issue,
   output logic [15:0] is_stallcount
);
   logic [31:1] pending_q, pending_d, clr, set;
   logic [31:0] pend_eff;
   logic [3:1]  wb_busy_q, wb_busy_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        unit_ok, src_haz, waw_haz, str_haz, go;

   always_comb begin
      clr = '0;
      set = '0;
      for (int i = 1; i < 32; i++) begin
         clr[i] = wb_is_writereg && (wb_is_regdest == 5'(i));
         set[i] = id_is_writereg && (id_is_regdest == 5'(i));
      end
`ifdef ISSUE_WB_BYPASS_EN
      pend_eff = {pending_q & ~clr, 1'b0};
`else
      pend_eff = {pending_q, 1'b0};
`endif
      // bit 0 of pend_eff is tied low so r0 never produces a hazard
      unit_ok     = (id_is_functionalunit == 2'd1) || (id_is_functionalunit == 2'd2);
      src_haz     = (id_is_readrs && pend_eff[id_is_rs]) || (id_is_readrt && pend_eff[id_is_rt]);
      waw_haz     = id_is_writereg && pend_eff[id_is_regdest];
      str_haz     = (id_is_functionalunit == 2'd2) && wb_busy_q[2];
      go          = !reset && id_is_valid && unit_ok && !(src_haz || waw_haz || str_haz);
      is_x_issue  = go && (id_is_functionalunit == 2'd1);
      is_m_issue  = go && (id_is_functionalunit == 2'd2);
      is_id_stall = reset || (id_is_valid && unit_ok && !go);
      wb_busy_d   = {is_x_issue, wb_busy_q[3], wb_busy_q[2] | is_m_issue};
      pending_d   = (pending_q & ~clr) | (go ? set : '0);
      stall_cnt_d = (is_id_stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
   end

   assign is_stallcount = stall_cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_q   <= '0;
         wb_busy_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         pending_q   <= pending_d;
         wb_busy_q   <= wb_busy_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: random and directed stimulus scored against a cycle-indexed reference model of the issue rules.
module tb_issue_scheduler;
   logic        clock = 0, reset = 1;
   logic        id_is_valid = 0, id_is_readrs = 0, id_is_readrt = 0, id_is_writereg = 0, wb_is_writereg = 0;
   logic [1:0]  id_is_functionalunit = 0;
   logic [4:0]  id_is_rs = 0, id_is_rt = 0, id_is_regdest = 0, wb_is_regdest = 0;
   logic        is_id_stall, is_x_issue, is_m_issue;
   logic [15:0] is_stallcount;

   issue_scheduler dut (
      .clock(clock), .reset(reset), .id_is_valid(id_is_valid), .id_is_functionalunit(id_is_functionalunit),
      .id_is_rs(id_is_rs), .id_is_rt(id_is_rt), .id_is_readrs(id_is_readrs), .id_is_readrt(id_is_readrt),
      .id_is_regdest(id_is_regdest), .id_is_writereg(id_is_writereg), .wb_is_regdest(wb_is_regdest),
      .wb_is_writereg(wb_is_writereg), .is_id_stall(is_id_stall), .is_x_issue(is_x_issue),
      .is_m_issue(is_m_issue), .is_stallcount(is_stallcount)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic        x, m, s;
      logic [15:0] c;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_checks = 0, n_fail = 0;
   bit   pend[32];
   bit   claim[int];
   int   cyc = 0, cnt_m = 0;

   function automatic void chk(string nm, logic [15:0] act, logic [15:0] req, int c);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, req);
      end
   endfunction

   function automatic bit pe(logic [4:0] r);
      bit b;
      b = (r != 0) && pend[r];
`ifdef ISSUE_WB_BYPASS_EN
      if (wb_is_writereg && wb_is_regdest == r) b = 0;
`endif
      return b;
   endfunction

   // writeback port claims are kept as absolute cycle numbers
   task automatic step(input bit v, input logic [1:0] u, input logic [4:0] rs, input logic [4:0] rt,
                       input bit rrs, input bit rrt, input logic [4:0] rd, input bit wr,
                       input logic [4:0] wrd, input bit ww, input bit rst);
      exp_t e;
      bit   ok, go;
      @(posedge clock);
      #1;
      reset = rst; id_is_valid = v; id_is_functionalunit = u; id_is_rs = rs; id_is_rt = rt;
      id_is_readrs = rrs; id_is_readrt = rrt; id_is_regdest = rd; id_is_writereg = wr;
      wb_is_regdest = wrd; wb_is_writereg = ww;
      e.cyc = cyc;
      if (rst) begin
         e.x = 0; e.m = 0; e.s = 1; e.c = 0;
         foreach (pend[i]) pend[i] = 0;
         claim.delete();
         cnt_m = 0;
      end else begin
         ok = (u == 1) || (u == 2);
         go = v && ok && !((rrs && pe(rs)) || (rrt && pe(rt)) || (wr && pe(rd)) || (u == 2 && claim.exists(cyc + 2)));
         e.x = go && u == 1;
         e.m = go && u == 2;
         e.s = v && ok && !go;
         e.c = 16'(cnt_m);
         if (ww) pend[wrd] = 0;
         if (go && wr && rd != 0) pend[rd] = 1;
         if (e.x) claim[cyc + 4] = 1;
         if (e.m) claim[cyc + 2] = 1;
         if (e.s && cnt_m < 65535) cnt_m++;
      end
      sbq.push_back(e);
      cyc++;
   endtask

   task automatic idle(input bit rst);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
   endtask

   always @(negedge clock) begin
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         chk("x_issue", 16'(is_x_issue), 16'(mon_e.x), mon_e.cyc);
         chk("m_issue", 16'(is_m_issue), 16'(mon_e.m), mon_e.cyc);
         chk("id_stall", 16'(is_id_stall), 16'(mon_e.s), mon_e.cyc);
         chk("stallcount", is_stallcount, mon_e.c, mon_e.cyc);
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle(1);
      idle(1);
      // RAW on r5 resolved by retire
      step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      repeat (3) step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 5, 0, 1, 0, 0, 0, 5, 1, 0);
      step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      repeat (5) idle(0);
      // M two cycles behind X collides on writeback
      step(1, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
      idle(0);
      step(1, 2, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      @(negedge clock); #1;
      chk("req023_stall", 16'(is_id_stall), 16'd1, cyc - 1);
      step(1, 2, 0, 0, 0, 0, 10, 1, 0, 0, 0);
      @(negedge clock); #1;
      chk("req023_m_issue", 16'(is_m_issue), 16'd1, cyc - 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 10, 1, 0);
      // retire and set of r7 in the same cycle leaves r7 pending
      step(1, 1, 0, 0, 0, 0, 7, 1, 7, 1, 0);
      step(1, 2, 7, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clock); #1;
      chk("req024_stall", 16'(is_id_stall), 16'd1, cyc - 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0);
      // r0 is never pending
      step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 2, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      @(negedge clock); #1;
      chk("req025_no_stall", 16'(is_id_stall), 16'd0, cyc - 1);
      repeat (5) idle(0);
      for (int i = 0; i < 2000; i++)
         step($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
              $urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0);
      idle(1);
      idle(0);
      // long stall saturates the counter, then reset mid-stall
      step(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      repeat (70000) step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clock); #1;
      chk("req026_saturate", is_stallcount, 16'hFFFF, cyc - 1);
      step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1);
      @(negedge clock); #1;
      chk("req026_rst_count", is_stallcount, 16'd0, cyc - 1);
      chk("req026_rst_stall", 16'(is_id_stall), 16'd1, cyc - 1);
      chk("req026_rst_issue", 16'({is_x_issue, is_m_issue}), 16'd0, cyc - 1);
      step(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clock); #1;
      chk("req018_post_reset_issue", 16'(is_x_issue), 16'd1, cyc - 1);
      idle(0);
      @(negedge clock); #1;
      chk("scoreboard_drained", 16'(sbq.size()), 16'd0, cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
